// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ------------
// Receive half of a UART. Frames arriving on the serial line (start bit,
// DATA_BITS payload bits LSB first, one stop bit) are deserialised and the
// completed bytes are queued in a first-word fall-through FIFO that a byte
// consumer drains with read_uart.
//
// One bit period lasts baud_divisor+1 clocks. The start bit is checked at
// its midpoint, and every later bit is sampled exactly one period after the
// previous sample, so all samples land near the middle of their bit.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   baud_divisor  clocks per bit minus one (>= 3), stable while a frame is in flight
//   rx            asynchronous serial input, idle high
//   read_uart     pop request, one byte per cycle while high
//   rx_data       FIFO head byte (valid while rx_empty is low)
//   rx_empty      FIFO holds no bytes
//   rx_full       FIFO holds 2**FIFO_ADDR_BITS bytes
//   frame_error   one-cycle pulse: stop bit sampled low
//   overrun       one-cycle pulse: finished byte dropped because the FIFO was full
module uart_rx_fifo #(
  parameter int DATA_BITS      = 8,
  parameter int COUNTER_BITS   = 16,
  parameter int FIFO_ADDR_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COUNTER_BITS-1:0] baud_divisor,
  input  logic                    rx,
  input  logic                    read_uart,
  output logic [DATA_BITS-1:0]    rx_data,
  output logic                    rx_empty,
  output logic                    rx_full,
  output logic                    frame_error,
  output logic                    overrun
);

  localparam int DEPTH    = 2 ** FIFO_ADDR_BITS;
  localparam int IDX_BITS = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  // Two-flop synchroniser for the asynchronous serial line.
  logic rxMeta_q;
  logic rxSync_q;
  logic rxS;

  // Receiver state.
  state_t                  state_q;
  logic [COUNTER_BITS-1:0] cnt_q;
  logic [IDX_BITS-1:0]     bitIdx_q;
  logic [DATA_BITS-1:0]    shift_q;
  logic                    frameErr_q;
  logic                    overrun_q;

  // FIFO storage and pointers; the extra pointer bit tells full from empty.
  logic [DATA_BITS-1:0]    mem [DEPTH];
  logic [FIFO_ADDR_BITS:0] wrPtr_q, wrPtr_d;
  logic [FIFO_ADDR_BITS:0] rdPtr_q, rdPtr_d;

  // Decoded conditions shared by the FSM and the FIFO.
  logic halfDivHit;
  logic fullDivHit;
  logic stopSample;
  logic doPop;
  logic doPush;
  logic dropByte;

  // The synchroniser idles high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  assign rxS = rxSync_q;

  assign halfDivHit = (cnt_q == (baud_divisor >> 1));
  assign fullDivHit = (cnt_q == baud_divisor);
  assign stopSample = (state_q == STOP) && fullDivHit;
  assign doPop      = read_uart && !rx_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign doPush     = stopSample && rxS && (!rx_full || doPop);
  assign dropByte   = stopSample && rxS && rx_full && !doPop;

  // Receiver FSM. The bit counter is cleared on every state entry, and the
  // error pulses are registered so they last exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rxS) begin
            state_q <= START;
          end
        end
        START: begin
          if (halfDivHit) begin
            cnt_q <= '0;
            // A line that is high again at mid start bit was only a glitch.
            if (!rxS) begin
              state_q  <= DATA;
              bitIdx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + COUNTER_BITS'(1);
          end
        end
        DATA: begin
          if (fullDivHit) begin
            cnt_q   <= '0;
            shift_q <= {rxS, shift_q[DATA_BITS-1:1]};
            if (bitIdx_q == IDX_BITS'(DATA_BITS - 1)) begin
              state_q <= STOP;
            end else begin
              bitIdx_q <= bitIdx_q + IDX_BITS'(1);
            end
          end else begin
            cnt_q <= cnt_q + COUNTER_BITS'(1);
          end
        end
        STOP: begin
          if (fullDivHit) begin
            cnt_q <= '0;
            if (rxS) begin
              state_q   <= IDLE;
              overrun_q <= dropByte;
            end else begin
              state_q    <= WAIT_HIGH;
              frameErr_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + COUNTER_BITS'(1);
          end
        end
        WAIT_HIGH: begin
          // Hold off until the line recovers so a break reports only once.
          cnt_q <= '0;
          if (rxS) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign frame_error = frameErr_q;
  assign overrun     = overrun_q;

  // Next pointer values; push and pop are independent and may coincide.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + (FIFO_ADDR_BITS + 1)'(1);
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + (FIFO_ADDR_BITS + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers define content.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr_q[FIFO_ADDR_BITS-1:0]] <= shift_q;
    end
  end

  assign rx_data  = mem[rdPtr_q[FIFO_ADDR_BITS-1:0]];
  assign rx_empty = (wrPtr_q == rdPtr_q);
  assign rx_full  = (wrPtr_q[FIFO_ADDR_BITS] != rdPtr_q[FIFO_ADDR_BITS]) &&
                    (wrPtr_q[FIFO_ADDR_BITS-1:0] == rdPtr_q[FIFO_ADDR_BITS-1:0]);

endmodule
